// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and key constants for the keypad scan reader
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_SCAN,
    ST_SAMPLE,
    ST_EMIT0,
    ST_EMIT1,
    ST_EMIT2,
    ST_EMIT3
  } scan_state_t;

  typedef struct packed {
    logic       press;
    logic [3:0] code;
  } key_evt_t;

  localparam logic [3:0] KEY_DO          = 4'd0;
  localparam logic [3:0] KEY_RE          = 4'd1;
  localparam logic [3:0] KEY_MI          = 4'd2;
  localparam logic [3:0] KEY_MODE_DX     = 4'd13;
  localparam logic [3:0] KEY_MODE_QHC    = 4'd14;
  localparam logic [3:0] KEY_MODE_MANUAL = 4'd15;

  function automatic logic [3:0] key_index(input logic [1:0] row_idx, input logic [1:0] col_idx);
    return {row_idx, col_idx};
  endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// rtl/keypad_evt_fifo.sv - synchronous key-event FIFO with full/empty and drop indication
module keypad_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             dropped
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop && !empty;
  // A pop in the same cycle frees the slot, so a push to a full queue still lands.
  assign push_ok  = push && (!full || pop_ok);
  assign dropped  = push && !push_ok;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scan_reader.sv
// rtl/keypad_scan_reader.sv - 4x4 keypad row scanner with per-key debounce and event queue
// Define KEYPAD_RELEASE_EVT_EN to queue release events as well as presses.
module keypad_scan_reader
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 12000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [3:0]  key_code,
  output logic        key_press,
  output logic [15:0] key_held,
  output logic        overflow
);

  localparam int DW = $clog2(SCAN_DIV);

  scan_state_t state;
  scan_state_t state_next;
  logic [DW-1:0] slot_cnt;
  logic          slot_last;
  logic [1:0]    row_idx;
  logic [1:0]    row_smp;
  logic [3:0]    col_smp;
  logic [3:0]    toggled;
  logic [3:0]    stab_cnt [16];

  logic          evt_push;
  key_evt_t      evt_in;
  key_evt_t      evt_head;
  logic [1:0]    emit_col;
  logic [3:0]    emit_key;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_dropped;
  logic          fifo_pop;

  assign slot_last = (slot_cnt == DW'(SCAN_DIV - 1));
  assign row       = ~(4'b0001 << row_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      row_idx  <= 2'd0;
      col_smp  <= 4'hF;
      row_smp  <= 2'd0;
    end else if (slot_last) begin
      slot_cnt <= '0;
      row_idx  <= row_idx + 2'd1;
      col_smp  <= col;
      row_smp  <= row_idx;
    end else begin
      slot_cnt <= slot_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_SCAN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    emit_col   = 2'd0;
    case (state)
      ST_SCAN:   if (slot_last) state_next = ST_SAMPLE;
      ST_SAMPLE: state_next = ST_EMIT0;
      ST_EMIT0:  begin emit_col = 2'd0; state_next = ST_EMIT1; end
      ST_EMIT1:  begin emit_col = 2'd1; state_next = ST_EMIT2; end
      ST_EMIT2:  begin emit_col = 2'd2; state_next = ST_EMIT3; end
      ST_EMIT3:  begin emit_col = 2'd3; state_next = ST_SCAN;  end
      default:   state_next = ST_SCAN;
    endcase
  end

  // The sampled row's four keys are debounced together in SAMPLE; EMITc then reads toggled[c].
  always_ff @(posedge clk) begin
    if (rst) begin
      key_held <= '0;
      toggled  <= '0;
      for (int k = 0; k < 16; k++) begin
        stab_cnt[k] <= '0;
      end
    end else if (state == ST_SAMPLE) begin
      for (int c = 0; c < 4; c++) begin
        if (!col_smp[c] != key_held[key_index(row_smp, 2'(c))]) begin
          if (stab_cnt[key_index(row_smp, 2'(c))] == 4'(DEBOUNCE_SCANS - 1)) begin
            key_held[key_index(row_smp, 2'(c))] <= !key_held[key_index(row_smp, 2'(c))];
            stab_cnt[key_index(row_smp, 2'(c))] <= '0;
            toggled[c] <= 1'b1;
          end else begin
            stab_cnt[key_index(row_smp, 2'(c))] <= stab_cnt[key_index(row_smp, 2'(c))] + 4'd1;
            toggled[c] <= 1'b0;
          end
        end else begin
          stab_cnt[key_index(row_smp, 2'(c))] <= '0;
          toggled[c] <= 1'b0;
        end
      end
    end
  end

  logic in_emit;
  assign in_emit  = (state == ST_EMIT0) || (state == ST_EMIT1) ||
                    (state == ST_EMIT2) || (state == ST_EMIT3);
  assign emit_key = key_index(row_smp, emit_col);

`ifdef KEYPAD_RELEASE_EVT_EN
  assign evt_push     = in_emit && toggled[emit_col];
  assign evt_in.press = key_held[emit_key];
`else
  assign evt_push     = in_emit && toggled[emit_col] && key_held[emit_key];
  assign evt_in.press = 1'b1;
`endif
  assign evt_in.code  = emit_key;

  assign fifo_pop = key_valid && key_ready;

  keypad_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (5)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (evt_push),
    .push_data (evt_in),
    .pop       (fifo_pop),
    .pop_data  (evt_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .dropped   (fifo_dropped)
  );

  assign key_valid = !fifo_empty;
  assign key_code  = key_valid ? evt_head.code : 4'd0;
  assign key_press = key_valid && evt_head.press;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (fifo_dropped) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_keypad_scan_reader.sv
// tb/tb_keypad_scan_reader.sv - directed self-checking bench for keypad_scan_reader
module tb_keypad_scan_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        key_valid;
  logic        key_ready = 1'b1;
  logic [3:0]  key_code;
  logic        key_press;
  logic [15:0] key_held;
  logic        overflow;

  logic [15:0] kp = 16'h0000;
  logic [4:0]  ev_q [$];
  logic [4:0]  ev;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  keypad_scan_reader #(
    .SCAN_DIV       (16),
    .DEBOUNCE_SCANS (2),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_code  (key_code),
    .key_press (key_press),
    .key_held  (key_held),
    .overflow  (overflow)
  );

  // Keypad model: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row[r]) col = col & ~kp[r*4 +: 4];
    end
  end

  always @(negedge clk) begin
    if (!rst && key_valid && key_ready) ev_q.push_back({key_press, key_code});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic next_ev(output logic [4:0] e);
    if (ev_q.size() > 0) e = ev_q.pop_front();
    else e = 5'bx;
  endtask

  task automatic wait_row(input logic [3:0] target);
    int n = 0;
    while (row !== target && n < 200) begin
      tick(1);
      n++;
    end
    check("wait_row", row, target);
  endtask

  initial begin
    logic [3:0] row_exp [5];
    row_exp[0] = 4'b1110; row_exp[1] = 4'b1101; row_exp[2] = 4'b1011;
    row_exp[3] = 4'b0111; row_exp[4] = 4'b1110;

    do_reset();
    check("rst_row", row, 4'b1110);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held", key_held, 16'h0000);
    check("rst_code", key_code, 4'd0);
    check("rst_press", key_press, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("row_seq%0d", i), row, row_exp[i]);
      tick(16);
    end

    // single key press and release
    ev_q.delete();
    kp = 16'h0001;
    tick(192);
    check("k0_held", key_held, 16'h0001);
    check("k0_nev", ev_q.size(), 1);
    next_ev(ev);
    check("k0_ev", ev, 5'h10);
    kp = 16'h0000;
    tick(192);
    check("k0_rel_held", key_held, 16'h0000);
`ifdef KEYPAD_RELEASE_EVT_EN
    check("k0_rel_nev", ev_q.size(), 1);
    next_ev(ev);
    check("k0_rel_ev", ev, 5'h00);
`else
    check("k0_rel_nev", ev_q.size(), 0);
`endif

    // one-sample glitch on key 13
    ev_q.delete();
    wait_row(4'b0111);
    kp = 16'h2000;
    wait_row(4'b1110);
    kp = 16'h0000;
    tick(192);
    check("glitch_held", key_held, 16'h0000);
    check("glitch_nev", ev_q.size(), 0);

    // whole row 2 pressed at once
    ev_q.delete();
    kp = 16'h0F00;
    tick(192);
    check("row2_held", key_held, 16'h0F00);
    check("row2_nev", ev_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      next_ev(ev);
      check($sformatf("row2_ev%0d", i), ev, 5'h18 + 5'(i));
    end
    kp = 16'h0000;
    tick(192);
    check("row2_rel_held", key_held, 16'h0000);
    ev_q.delete();

    // overflow with consumer stalled
    key_ready = 1'b0;
    wait_row(4'b1110);
    kp = 16'h001F;
    tick(192);
    check("ovf_held", key_held, 16'h001F);
    check("ovf_valid", key_valid, 1'b1);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_head", {key_press, key_code}, 5'h10);
    tick(3);
    check("ovf_stable", {key_press, key_code}, 5'h10);
    key_ready = 1'b1;
    tick(8);
    check("ovf_nev", ev_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      next_ev(ev);
      check($sformatf("ovf_ev%0d", i), ev, 5'h10 + 5'(i));
    end
    check("ovf_sticky", overflow, 1'b1);
    check("ovf_drained", key_valid, 1'b0);
    kp = 16'h0000;
    tick(192);
    ev_q.delete();

    // reset landing in EMIT2 of the second row-0 sample
    key_ready = 1'b0;
    kp = 16'h000F;
    do_reset();
    tick(83);
    check("emit_pre_valid", key_valid, 1'b1);
    check("emit_pre_code", key_code, 4'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("emit_rst_valid", key_valid, 1'b0);
    check("emit_rst_row", row, 4'b1110);
    check("emit_rst_held", key_held, 16'h0000);
    check("emit_rst_ovf", overflow, 1'b0);
    tick(3);
    check("emit_rst_quiet", key_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
